mips_boot_sequencer: RTL
========================

MIPS_BOOT_SEQUENCER -- requirements
Module: mips_boot_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the instruction and data word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the byte-address width of instruction and data memory.
REQ-003 The block SHALL have parameter MAX_WORDS, default 256, meaning the maximum program length in words.
REQ-004 The block SHALL have parameter CNT_WIDTH, default 16, meaning the width of the run-cycle counter.
REQ-005 The block SHALL have one clock and synchronous active-high reset: clock input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-006 The block SHALL have these ports (name, direction, width, meaning):
- start  input  1  begin a load/run/check sequence.
- prog_len  input  $clog2(MAX_WORDS+1)  number of program words, sampled at start.
- run_cycles  input  CNT_WIDTH  number of execute cycles, sampled at start.
- check_addr  input  ADDR_WIDTH  data-memory byte address to check, sampled at start.
- expected  input  DATA_WIDTH  expected data-memory word, sampled at start.
- prog_valid  input  1  program word available.
- prog_data  input  DATA_WIDTH  program word.
- prog_ready  output  1  block accepts prog_data this cycle.
- inst_memory_load_enable  output  1  instruction-memory write strobe.
- inst_memory_write_addr  output  ADDR_WIDTH  instruction-memory byte address.
- inst_memory_write_data  output  DATA_WIDTH  instruction word.
- PC_reset  output  1  holds the processor PC in reset.
- data_memory_addr  output  ADDR_WIDTH  data-memory check address.
- data_memory_read_data  input  DATA_WIDTH  combinational data-memory read.
- busy, done, pass, error  output  1 each  status.

Function
REQ-007 The FSM SHALL have the states IDLE, LOAD, RUN, SETTLE, CHECK and DONE.
REQ-008 In IDLE, a start pulse SHALL latch prog_len, run_cycles, check_addr and expected, and clear done, pass and error.
REQ-009 On start with prog_len > MAX_WORDS, the FSM SHALL go to DONE with error=1 and pass=0, and SHALL NOT write any instruction word.
REQ-010 On start with prog_len=0, the FSM SHALL skip LOAD and go to RUN.
REQ-011 In LOAD, prog_ready SHALL be 1, and each cycle with prog_valid=1 SHALL be a transfer.
REQ-012 Each transfer SHALL drive inst_memory_load_enable=1 and inst_memory_write_data=prog_data in the same cycle.
REQ-013 The first word SHALL be written at inst_memory_write_addr=0, and each later word at the previous address + DATA_WIDTH/8.
REQ-014 A cycle with prog_valid=0 in LOAD SHALL be a stall: no write, no address advance.
REQ-015 After transfer number prog_len, the FSM SHALL go to RUN on the next edge, and prog_ready SHALL be 0 from that edge.
REQ-016 PC_reset SHALL be 1 in every state except RUN.
REQ-017 RUN SHALL last exactly run_cycles clock cycles with PC_reset=0; run_cycles=0 SHALL go directly to SETTLE.
REQ-018 data_memory_addr SHALL equal the latched check_addr in SETTLE and CHECK, and 0 otherwise.
REQ-019 SETTLE SHALL last one cycle.
REQ-020 CHECK SHALL register pass = (data_memory_read_data == expected), then go to DONE.
REQ-021 DONE SHALL hold done=1 and return to IDLE on the next start, which is treated as a new sequence.
REQ-022 busy SHALL be 1 in LOAD, RUN, SETTLE and CHECK.
REQ-023 start while busy SHALL be ignored.
REQ-024 The address and run counters SHALL wrap modulo their widths without error; only prog_len > MAX_WORDS SHALL flag error.

Reset
REQ-025 reset SHALL force IDLE, PC_reset=1, and prog_ready, inst_memory_load_enable, busy, done, pass and error all 0.
REQ-026 reset SHALL force inst_memory_write_addr, inst_memory_write_data and data_memory_addr to 0.
REQ-027 reset mid-LOAD or mid-RUN SHALL abort the sequence with no further instruction-memory write after the reset edge.
REQ-028 reset SHALL take priority over start in the same cycle.

Structure
REQ-029 State encodings and the WORD_BYTES constant SHALL live in the shared package mips_pkg.
REQ-030 The run-cycle countdown SHALL be a sub-module mips_cycle_counter, with load, enable and zero flag, parametrised by CNT_WIDTH.

Verification
REQ-031 The bench SHALL cover: prog_len=3, words 0x3F, 0x2001000A, 0xAC010000, prog_valid always high -> writes at addresses 0, 4, 8 on three consecutive cycles, then RUN.
REQ-032 The bench SHALL cover: same program, run_cycles=3, check_addr=0, expected=0xA, memory model returns 0xA -> done=1, pass=1, error=0.
REQ-033 The bench SHALL cover: memory model returns 0x5 at the check -> done=1, pass=0.
REQ-034 The bench SHALL cover: prog_valid toggling 1,0,0,1,1 with prog_len=3 -> exactly three writes at 0, 4, 8, with no address advance during stalls.
REQ-035 The bench SHALL cover: prog_len=MAX_WORDS+1 -> error=1 and done=1 within 2 cycles, with inst_memory_load_enable never asserted.
REQ-036 The bench SHALL cover: reset asserted during the second LOAD transfer -> IDLE next cycle, PC_reset=1, and no write at address 8.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the boot sequencer slice.
// Holds the sequencer state encoding, the default word size in bytes and a
// helper that derives the byte stride of a word from its bit width.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Byte stride between consecutive instruction words of the given width.
  function automatic int unsigned word_bytes(input int unsigned data_width);
    return data_width / 32'd8;
  endfunction

  // Stride for the default 32-bit MIPS word.
  localparam int unsigned WORD_BYTES = word_bytes(32'd32);

endpackage

// File: rtl/mips_boot_sequencer_if.sv
// mips_boot_sequencer_if: bus bundle between the boot sequencer and its
// environment.
// Signals: program stream (prog_valid/prog_data/prog_ready), instruction
// memory write port (inst_memory_*), data memory check port
// (data_memory_addr out, data_memory_read_data combinational back).
// Modports: slave = the sequencer, master = program source and memories.
interface mips_boot_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();

  logic                  prog_valid;
  logic [DATA_WIDTH-1:0] prog_data;
  logic                  prog_ready;
  logic                  inst_memory_load_enable;
  logic [ADDR_WIDTH-1:0] inst_memory_write_addr;
  logic [DATA_WIDTH-1:0] inst_memory_write_data;
  logic [ADDR_WIDTH-1:0] data_memory_addr;
  logic [DATA_WIDTH-1:0] data_memory_read_data;

  modport slave (
    input  prog_valid, prog_data, data_memory_read_data,
    output prog_ready, inst_memory_load_enable, inst_memory_write_addr,
           inst_memory_write_data, data_memory_addr
  );

  modport master (
    output prog_valid, prog_data, data_memory_read_data,
    input  prog_ready, inst_memory_load_enable, inst_memory_write_addr,
           inst_memory_write_data, data_memory_addr
  );

endinterface

// File: rtl/mips_cycle_counter.sv
// mips_cycle_counter: down-counter that times the RUN phase.
// Ports: clk, reset (sync, active-high); load + load_value preset the count;
// enable decrements by one (wrapping); zero flags a count of zero.
module mips_cycle_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] load_value,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] count_r;

  // Countdown register; a load takes precedence over a decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_value;
    end else if (enable) begin
      count_r <= count_r - CNT_WIDTH'(1);
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/mips_boot_sequencer.sv
// mips_boot_sequencer: loads a program into instruction memory, releases the
// processor PC for a fixed number of cycles, then compares one data-memory
// word with an expected value.
// Ports: clk, reset (sync, active-high); start with prog_len, run_cycles,
// check_addr and expected (sampled when a start is accepted); bus carries
// the program stream and both memory ports; PC_reset holds the core in reset
// outside RUN; busy/done/pass/error report sequence status.
module mips_boot_sequencer
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WORDS  = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [$clog2(MAX_WORDS+1)-1:0] prog_len,
  input  logic [CNT_WIDTH-1:0]           run_cycles,
  input  logic [ADDR_WIDTH-1:0]          check_addr,
  input  logic [DATA_WIDTH-1:0]          expected,
  mips_boot_sequencer_if.slave           bus,
  output logic                           PC_reset,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic                           error
);

  localparam int          LEN_WIDTH = $clog2(MAX_WORDS + 1);
  localparam int unsigned STEP      = word_bytes(DATA_WIDTH);

  state_t                state_r, state_s;
  logic [LEN_WIDTH-1:0]  prog_len_r, count_r;
  logic [CNT_WIDTH-1:0]  run_cycles_r;
  logic [ADDR_WIDTH-1:0] check_addr_r, addr_r;
  logic [DATA_WIDTH-1:0] expected_r;
  logic                  done_r, pass_r, error_r;

  logic                  start_ok_s, too_long_s, prog_ready_s, xfer_s, last_xfer_s;
  logic                  cnt_load_s, cnt_zero_s;
  logic [CNT_WIDTH-1:0]  cnt_load_value_s;

  // A start is only honoured when no sequence is in flight.
  assign start_ok_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign too_long_s  = (prog_len > LEN_WIDTH'(MAX_WORDS));
  // Reset suppresses the handshake in its own cycle so no write escapes it.
  assign prog_ready_s = (state_r == ST_LOAD) && !reset;
  assign xfer_s       = prog_ready_s && bus.prog_valid;
  assign last_xfer_s  = xfer_s && ((count_r + LEN_WIDTH'(1)) == prog_len_r);

  // Next-state selection.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (!start) begin
          state_s = state_r;
        end else if (too_long_s) begin
          state_s = ST_DONE;
        end else if (prog_len != '0) begin
          state_s = ST_LOAD;
        end else if (run_cycles != '0) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_SETTLE;
        end
      end
      ST_LOAD: begin
        if (!last_xfer_s) begin
          state_s = ST_LOAD;
        end else if (run_cycles_r != '0) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_SETTLE;
        end
      end
      ST_RUN: begin
        if (cnt_zero_s) begin
          state_s = ST_SETTLE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_SETTLE: state_s = ST_CHECK;
      ST_CHECK:  state_s = ST_DONE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // The counter is preset to N-1 on entry to RUN so that RUN spans N cycles
  // and ends on the cycle the count reads zero.
  assign cnt_load_s       = (state_s == ST_RUN) && (state_r != ST_RUN);
  assign cnt_load_value_s = (start_ok_s ? run_cycles : run_cycles_r) - CNT_WIDTH'(1);

  mips_cycle_counter #(.CNT_WIDTH(CNT_WIDTH)) u_run_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load_s),
    .enable     (state_r == ST_RUN),
    .load_value (cnt_load_value_s),
    .zero       (cnt_zero_s)
  );

  // State, latched sequence parameters, load pointer and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      prog_len_r   <= '0;
      run_cycles_r <= '0;
      check_addr_r <= '0;
      expected_r   <= '0;
      count_r      <= '0;
      addr_r       <= '0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      if (start_ok_s) begin
        prog_len_r   <= prog_len;
        run_cycles_r <= run_cycles;
        check_addr_r <= check_addr;
        expected_r   <= expected;
        count_r      <= '0;
        addr_r       <= '0;
        pass_r       <= 1'b0;
        done_r       <= too_long_s;
        error_r      <= too_long_s;
      end else begin
        if (xfer_s) begin
          count_r <= count_r + LEN_WIDTH'(1);
          addr_r  <= addr_r + ADDR_WIDTH'(STEP);
        end
        if (state_r == ST_CHECK) begin
          pass_r <= (bus.data_memory_read_data == expected_r);
          done_r <= 1'b1;
        end
      end
    end
  end

  assign bus.prog_ready              = prog_ready_s;
  assign bus.inst_memory_load_enable = xfer_s;
  assign bus.inst_memory_write_addr  = addr_r;
  assign bus.inst_memory_write_data  = xfer_s ? bus.prog_data : '0;
  assign bus.data_memory_addr        = ((state_r == ST_SETTLE) || (state_r == ST_CHECK))
                                       ? check_addr_r : '0;
  assign PC_reset = (state_r != ST_RUN);
  assign busy     = (state_r == ST_LOAD) || (state_r == ST_RUN) ||
                    (state_r == ST_SETTLE) || (state_r == ST_CHECK);
  assign done     = done_r;
  assign pass     = pass_r;
  assign error    = error_r;

endmodule
